// File: rtl/occupancy_sensor.sv
// ----------------------------------------------------------------------------
// occupancy_sensor
//
// Produces the "person in room" signal for the room light controller. Two IR
// beams in the door frame are synchronized and debounced. A crossing FSM works
// out the walking direction from the filtered beams and keeps a saturating
// occupancy count.
//
// Beam A is on the corridor side and beam B is on the room side. A crossing
// that breaks A, then B, then clears counts as an entry. A crossing that
// breaks B, then A, then clears counts as an exit.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   beam_a       corridor-side beam, asynchronous, 1 = broken
//   beam_b       room-side beam, asynchronous, 1 = broken
//   present      registered (occupancy != 0)
//   occupancy    current person count, saturating at MAX_OCC and at 0
//   entry_pulse  one-cycle pulse on a committed entry
//   exit_pulse   one-cycle pulse on a committed exit
//   error_pulse  one-cycle pulse on a crossing timeout or an ambiguous start
// ----------------------------------------------------------------------------
module occupancy_sensor #(
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CNT_W          = 4,
    parameter int unsigned MAX_OCC        = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beam_a,
    input  logic             beam_b,
    output logic             present,
    output logic [CNT_W-1:0] occupancy,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             error_pulse
);

    localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DebW-1:0]  DebLast = DebW'(DEB_CYCLES - 1);
    localparam logic [TmrW-1:0]  TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] OccMax  = CNT_W'(MAX_OCC);

    typedef enum logic [2:0] {
        StIdle,
        StInA,
        StInAb,
        StInB,
        StOutB,
        StOutAb,
        StOutA,
        StWaitClear
    } state_e;

    // ------------------------------------------------------------------------
    // Input path. Bit 0 carries beam A and bit 1 carries beam B.
    // ------------------------------------------------------------------------
    logic [1:0] beam_raw;
    logic [1:0] meta_q;
    logic [1:0] sync_q;
    logic [1:0] filt_q;
    logic [1:0] filt_d;

    logic [1:0][DebW-1:0] deb_cnt_q;
    logic [1:0][DebW-1:0] deb_cnt_d;

    assign beam_raw = {beam_b, beam_a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= beam_raw;
            sync_q <= meta_q;
        end
    end

    // The counter tracks how many consecutive cycles the synchronized level has
    // disagreed with the filtered level. Any agreement, even a single cycle,
    // restarts the count. The filtered level flips on the DEB_CYCLES-th
    // consecutive disagreeing cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i]    = filt_q[i];
            deb_cnt_d[i] = '0;
            if (sync_q[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Crossing FSM, timeout timer and occupancy counter
    // ------------------------------------------------------------------------
    logic a;
    logic b;

    assign a = filt_q[0];
    assign b = filt_q[1];

    state_e           state_q;
    state_e           state_d;
    logic [TmrW-1:0]  tmr_q;
    logic [TmrW-1:0]  tmr_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic             present_q;
    logic             present_d;
    logic             entry_q;
    logic             entry_d;
    logic             exit_q;
    logic             exit_d;
    logic             error_q;
    logic             error_d;
    logic             tracking;

    // The timer only runs while a crossing is in progress.
    assign tracking = (state_q != StIdle) && (state_q != StWaitClear);

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        occ_d   = occ_q;
        entry_d = 1'b0;
        exit_d  = 1'b0;
        error_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (a && b) begin
                    // Both beams broken at once, so the direction is unknown.
                    state_d = StWaitClear;
                    error_d = 1'b1;
                end else if (a && !b) begin
                    state_d = StInA;
                end else if (!a && b) begin
                    state_d = StOutB;
                end
            end

            StInA: begin
                if (a && b)        state_d = StInAb;
                else if (!a && b)  state_d = StInB;
                else if (!a && !b) state_d = StIdle;
            end

            StInAb: begin
                if (!a && b)       state_d = StInB;
                else if (a && !b)  state_d = StInA;
                else if (!a && !b) state_d = StIdle;
            end

            StInB: begin
                if (!a && !b) begin
                    state_d = StIdle;
                    entry_d = 1'b1;
                    occ_d   = (occ_q == OccMax) ? occ_q : occ_q + 1'b1;
                end else if (a && b) begin
                    state_d = StInAb;
                end else if (a && !b) begin
                    state_d = StInA;
                end
            end

            StOutB: begin
                if (a && b)        state_d = StOutAb;
                else if (a && !b)  state_d = StOutA;
                else if (!a && !b) state_d = StIdle;
            end

            StOutAb: begin
                if (a && !b)       state_d = StOutA;
                else if (!a && b)  state_d = StOutB;
                else if (!a && !b) state_d = StIdle;
            end

            StOutA: begin
                if (!a && !b) begin
                    state_d = StIdle;
                    exit_d  = 1'b1;
                    occ_d   = (occ_q == '0) ? occ_q : occ_q - 1'b1;
                end else if (a && b) begin
                    state_d = StOutAb;
                end else if (!a && b) begin
                    state_d = StOutB;
                end
            end

            StWaitClear: begin
                if (!a && !b) state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A real transition wins over a timeout in the same cycle. The timeout
        // is only checked while the FSM is holding its state.
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (tracking) begin
            if (tmr_q == TmrLast) begin
                state_d = StWaitClear;
                error_d = 1'b1;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        present_d = (occ_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            occ_q     <= '0;
            present_q <= 1'b0;
            entry_q   <= 1'b0;
            exit_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            occ_q     <= occ_d;
            present_q <= present_d;
            entry_q   <= entry_d;
            exit_q    <= exit_d;
            error_q   <= error_d;
        end
    end

    assign present     = present_q;
    assign occupancy   = occ_q;
    assign entry_pulse = entry_q;
    assign exit_pulse  = exit_q;
    assign error_pulse = error_q;

endmodule
